// File: rtl/trap_event_pkg.sv
// Shared definitions for the trap-event producer: termination codes, FSM
// states and helpers that pick the trap lane and count the lanes retired with it.
package trap_event_pkg;

  localparam logic [2:0] TRAP_GOOD  = 3'd0;
  localparam logic [2:0] TRAP_BAD   = 3'd1;
  localparam logic [2:0] TRAP_ABORT = 3'd2;
  localparam logic [2:0] TRAP_LIMIT = 3'd3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REPORT = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Lanes are held in a 4-bit vector because commit width never exceeds four.
  function automatic logic [1:0] lowest_set_idx(input logic [3:0] v);
    lowest_set_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = 2'(i);
    end
  endfunction

  function automatic logic [2:0] count_upto(input logic [3:0] v, input logic [1:0] idx);
    count_upto = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(idx)) count_upto = count_upto + {2'b00, v[i]};
    end
  endfunction

endpackage

// File: rtl/trap_watchdog.sv
// Saturating no-commit counter; timeout fires on the cycle the count reaches WDOG_CYCLES.
module trap_watchdog #(
  parameter int WDOG_CYCLES = 5000
) (
  input  logic io_clock,
  input  logic io_rst_n,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WDOG_CYCLES);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge io_clock or negedge io_rst_n) begin
    if (!io_rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (clr)               cnt <= '0;
      else if (cnt != LIMIT) cnt <= cnt + 1'b1;
    end
  end

  // Look one count ahead so the abort is detected in the cycle that completes the run.
  assign timeout = en && !clr && (cnt >= LIMIT - 1'b1);

endmodule

// File: rtl/trap_event_gen.sv
// Difftest trap-event producer: counts cycles/commits, detects trap, limit and
// watchdog termination, and emits a one-cycle registered trap record.
module trap_event_gen
  import trap_event_pkg::*;
#(
  parameter logic [7:0]  COREID      = 8'd0,
  parameter int          COMMIT_W    = 2,
  parameter logic [63:0] INSTR_LIMIT = 64'd0,
  parameter int          WDOG_CYCLES = 5000
) (
  input  logic                  io_clock,
  input  logic                  io_rst_n,
  input  logic [COMMIT_W-1:0]   io_commit_valid,
  input  logic [COMMIT_W-1:0]   io_commit_trap,
  input  logic [64*COMMIT_W-1:0] io_commit_pc,
  input  logic [63:0]           io_trap_a0,
  output logic [7:0]            io_coreid,
  output logic                  io_valid,
  output logic [63:0]           io_cycleCnt,
  output logic [63:0]           io_instrCnt,
  output logic [2:0]            io_code,
  output logic [63:0]           io_pc,
  output logic                  io_halt
);

  state_t      state;
  logic [63:0] cyc, instr, last_pc;
  logic [3:0]  valid4, trap_hit, cnt_mask;
  logic [1:0]  trap_idx;
  logic [2:0]  n_cnt, det_code;
  logic [63:0] instr_next, trap_pc, hi_pc, det_pc;
  logic        any_trap, limit_hit, wdog_to, detect;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    valid4   = '0;
    trap_hit = '0;
    valid4[COMMIT_W-1:0]   = io_commit_valid;
    trap_hit[COMMIT_W-1:0] = io_commit_valid & io_commit_trap;
    any_trap = |trap_hit;
    trap_idx = lowest_set_idx(trap_hit);
    n_cnt    = count_upto(valid4, any_trap ? trap_idx : 2'd3);
    cnt_mask = '0;
    trap_pc  = '0;
    hi_pc    = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      cnt_mask[i] = valid4[i] && (!any_trap || i <= int'(trap_idx));
      if (cnt_mask[i])                  hi_pc   = io_commit_pc[64*i +: 64];
      if (any_trap && i == int'(trap_idx)) trap_pc = io_commit_pc[64*i +: 64];
    end
    instr_next = instr + 64'(n_cnt);
    limit_hit  = (INSTR_LIMIT != 64'd0) && (instr_next >= INSTR_LIMIT);
    detect     = (state == RUN) && (any_trap || limit_hit || wdog_to);
    if (any_trap) begin
      det_code = (io_trap_a0 == 64'd0) ? TRAP_GOOD : TRAP_BAD;
      det_pc   = trap_pc;
    end else if (limit_hit) begin
      det_code = TRAP_LIMIT;
      det_pc   = hi_pc;
    end else begin
      det_code = TRAP_ABORT;
      det_pc   = last_pc;
    end
  end

  trap_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .io_clock (io_clock),
    .io_rst_n (io_rst_n),
    .en       (state == RUN),
    .clr      (|io_commit_valid),
    .timeout  (wdog_to)
  );

  always_ff @(posedge io_clock or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state    <= RUN;
      cyc      <= '0;
      instr    <= '0;
      last_pc  <= '0;
      io_valid <= 1'b0;
      io_code  <= TRAP_GOOD;
      io_pc    <= '0;
      io_halt  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cyc   <= cyc + 64'd1;
          instr <= instr_next;
          if (|cnt_mask) last_pc <= hi_pc;
          if (detect) begin
            state    <= REPORT;
            io_valid <= 1'b1;
            io_code  <= det_code;
            io_pc    <= det_pc;
            io_halt  <= 1'b1;
          end
        end
        REPORT: begin
          state    <= HALTED;
          io_valid <= 1'b0;
        end
        default: io_valid <= 1'b0;
      endcase
    end
  end

  assign io_coreid   = COREID;
  assign io_cycleCnt = cyc;
  assign io_instrCnt = instr;

endmodule

// File: tb/tb_trap_event_gen.sv
// Scoreboard bench for trap_event_gen: one DUT without an instruction limit,
// one with INSTR_LIMIT=4; both use an 8-cycle watchdog.
module tb_trap_event_gen;

  typedef struct {
    logic [2:0]  code;
    logic [63:0] pc;
    logic [63:0] cyc;
    logic [63:0] instr;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   cv = '0, ct = '0;
  logic [127:0] cpc = '0;
  logic [63:0]  a0 = '0;

  logic [7:0]  coreid0, coreid1;
  logic        valid0, valid1, halt0, halt1;
  logic [63:0] cyc0, cyc1, ins0, ins1, pc0, pc1;
  logic [2:0]  code0, code1;

  rec_t q0[$];
  rec_t q1[$];
  bit   lim_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  trap_event_gen #(.COREID(8'd3), .COMMIT_W(2), .INSTR_LIMIT(64'd0), .WDOG_CYCLES(8)) dut (
    .io_clock(clk), .io_rst_n(rst_n), .io_commit_valid(cv), .io_commit_trap(ct),
    .io_commit_pc(cpc), .io_trap_a0(a0), .io_coreid(coreid0), .io_valid(valid0),
    .io_cycleCnt(cyc0), .io_instrCnt(ins0), .io_code(code0), .io_pc(pc0), .io_halt(halt0));

  trap_event_gen #(.COREID(8'd7), .COMMIT_W(2), .INSTR_LIMIT(64'd4), .WDOG_CYCLES(8)) dut_lim (
    .io_clock(clk), .io_rst_n(rst_n), .io_commit_valid(cv), .io_commit_trap(ct),
    .io_commit_pc(cpc), .io_trap_a0(a0), .io_coreid(coreid1), .io_valid(valid1),
    .io_cycleCnt(cyc1), .io_instrCnt(ins1), .io_code(code1), .io_pc(pc1), .io_halt(halt1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [2:0] code, input logic [63:0] pc, cyc, instr);
    rec_t r;
    r.code = code; r.pc = pc; r.cyc = cyc; r.instr = instr;
    q0.push_back(r);
  endtask

  task automatic push1(input logic [2:0] code, input logic [63:0] pc, cyc, instr);
    rec_t r;
    r.code = code; r.pc = pc; r.cyc = cyc; r.instr = instr;
    q1.push_back(r);
  endtask

  // Hold one cycle of commit inputs across the next rising edge.
  task automatic drive(input logic [1:0] v, t, input logic [63:0] p0, p1, trap_a0);
    cv = v; ct = t; cpc = {p1, p0}; a0 = trap_a0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
  endtask

  // Reset is asserted mid-cycle and outputs are checked before the next edge.
  task automatic do_reset();
    cv = '0; ct = '0; cpc = '0; a0 = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {63'd0, valid0}, 64'd0);
    check("rst_halt",  {63'd0, halt0},  64'd0);
    check("rst_code",  {61'd0, code0},  64'd0);
    check("rst_pc",    pc0,  64'd0);
    check("rst_cyc",   cyc0, 64'd0);
    check("rst_instr", ins0, 64'd0);
    check("rst_halt_lim", {63'd0, halt1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_drained(input string tag);
    check({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
    check({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
    q0.delete();
    q1.delete();
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (rst_n && valid0) begin
      if (q0.size() == 0) begin
        check("dut_unexpected_valid", {63'd0, valid0}, 64'd0);
      end else begin
        e = q0.pop_front();
        check("dut_code",  {61'd0, code0}, {61'd0, e.code});
        check("dut_pc",    pc0,  e.pc);
        check("dut_cyc",   cyc0, e.cyc);
        check("dut_instr", ins0, e.instr);
        check("dut_halt",  {63'd0, halt0}, 64'd1);
      end
    end
    if (rst_n && lim_en && valid1) begin
      if (q1.size() == 0) begin
        check("lim_unexpected_valid", {63'd0, valid1}, 64'd0);
      end else begin
        e = q1.pop_front();
        check("lim_code",  {61'd0, code1}, {61'd0, e.code});
        check("lim_pc",    pc1,  e.pc);
        check("lim_cyc",   cyc1, e.cyc);
        check("lim_instr", ins1, e.instr);
      end
    end
  end

  initial begin
    do_reset();
    check("coreid", {56'd0, coreid0}, 64'd3);

    // Good trap after ten single-lane commits, then commits/traps while halted.
    for (int i = 0; i < 10; i++) drive(2'b01, 2'b00, 64'h8000_0000 + 64'(4 * i), 64'd0, 64'd0);
    push0(3'd0, 64'h8000_0100, 64'd11, 64'd11);
    drive(2'b01, 2'b01, 64'h8000_0100, 64'd0, 64'd0);
    for (int i = 0; i < 5; i++) drive(2'b11, 2'b11, 64'h9000_0000, 64'h9000_0004, 64'd7);
    check("halt_cyc",   cyc0, 64'd11);
    check("halt_instr", ins0, 64'd11);
    check("halt_code",  {61'd0, code0}, 64'd0);
    check("halt_pc",    pc0, 64'h8000_0100);
    check("halt_sticky", {63'd0, halt0}, 64'd1);
    check("halt_valid", {63'd0, valid0}, 64'd0);
    expect_drained("good");

    // Bad trap on lane 1 with lane 0 valid: both lanes counted.
    do_reset();
    drive(2'b11, 2'b00, 64'h8000_0200, 64'h8000_0204, 64'd0);
    drive(2'b11, 2'b00, 64'h8000_0208, 64'h8000_020c, 64'd0);
    push0(3'd1, 64'h8000_0214, 64'd3, 64'd6);
    drive(2'b11, 2'b10, 64'h8000_0210, 64'h8000_0214, 64'd5);
    idle(2);
    expect_drained("bad");

    // Trap on lane 0 with lane 1 valid (and flagged): lane 1 ignored.
    do_reset();
    drive(2'b11, 2'b00, 64'h8000_02f8, 64'h8000_02fc, 64'd0);
    push0(3'd0, 64'h8000_0300, 64'd2, 64'd3);
    drive(2'b11, 2'b11, 64'h8000_0300, 64'h8000_0304, 64'd0);
    idle(2);
    expect_drained("lane0");

    // Watchdog after one commit.
    do_reset();
    push0(3'd2, 64'h8000_0004, 64'd9, 64'd1);
    drive(2'b01, 2'b00, 64'h8000_0004, 64'd0, 64'd0);
    idle(12);
    expect_drained("wdog");

    // Watchdog with no commit ever.
    do_reset();
    push0(3'd2, 64'd0, 64'd8, 64'd0);
    idle(12);
    expect_drained("wdog0");

    // Limit and trap in the same cycle: trap wins.
    do_reset();
    lim_en = 1'b1;
    for (int i = 0; i < 3; i++) drive(2'b01, 2'b00, 64'h8000_03f0 + 64'(4 * i), 64'd0, 64'd0);
    push0(3'd0, 64'h8000_0400, 64'd4, 64'd4);
    push1(3'd0, 64'h8000_0400, 64'd4, 64'd4);
    drive(2'b01, 2'b01, 64'h8000_0400, 64'd0, 64'd0);
    idle(2);
    expect_drained("lim_trap");

    // Limit alone on a single lane.
    do_reset();
    for (int i = 0; i < 3; i++) drive(2'b01, 2'b00, 64'h8000_0500 + 64'(4 * i), 64'd0, 64'd0);
    push1(3'd3, 64'h8000_050c, 64'd4, 64'd4);
    drive(2'b01, 2'b00, 64'h8000_050c, 64'd0, 64'd0);
    idle(2);
    check("nolimit_running", {63'd0, halt0}, 64'd0);
    expect_drained("limit");

    // Limit crossed by a dual-lane commit: pc is the highest counted lane.
    do_reset();
    drive(2'b11, 2'b00, 64'h8000_05f0, 64'h8000_05f4, 64'd0);
    drive(2'b01, 2'b00, 64'h8000_05f8, 64'd0, 64'd0);
    push1(3'd3, 64'h8000_0604, 64'd3, 64'd5);
    drive(2'b11, 2'b00, 64'h8000_0600, 64'h8000_0604, 64'd0);
    idle(2);
    expect_drained("limit2");

    lim_en = 1'b0;
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
